// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front-end.
// State encodings sit beside the reset PC default so the datapath can reuse them.
package fetch_unit_pkg;

  localparam logic [1:0] FETCH_REQ     = 2'd0;
  localparam logic [1:0] FETCH_WAIT    = 2'd1;
  localparam logic [1:0] FETCH_DISCARD = 2'd2;
  localparam logic [1:0] FETCH_IDLE    = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int          FIFO_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } fetchEntry_t;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and a head read straight from storage flops.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             headValid,
  output logic [WIDTH-1:0] headData
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && (count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign doPush = push && ((count != CW'(DEPTH)) || doPop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PW'(1);
      end
      if (doPop) rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign headValid = (count != '0);
  assign headData  = mem[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: one outstanding imem read, buffered words with PCs,
// valid/ready delivery to the datapath and redirect with flush of buffered/in-flight words.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic        oValid,
  output logic [31:0] oInstruction,
  output logic [31:0] oPc,
  input  logic        iReady,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic [1:0]  dbgState
);

  // Handshakes: a beat moves only in a cycle where both valid and ready are high;
  // imemReq/imemAddr and oValid/oInstruction/oPc hold until their beat moves or a redirect flushes.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic [1:0]    stateNext;
  logic [31:0]   fetchPc;
  logic [31:0]   pcNext;
  logic          reqEnable;
  logic          transfer;
  logic          pop;
  logic          pushEn;
  logic [CW-1:0] count;
  logic [CW:0]   countAfterPush;
  fetchEntry_t   pushEntry;
  fetchEntry_t   headEntry;

  // reqEnable keeps imemReq low while reset is held and for the release cycle.
  assign imemReq  = reqEnable && (state == FETCH_REQ);
  assign imemAddr = fetchPc;
  assign transfer = imemReq && imemReady;
  assign pop      = oValid && iReady;
  assign dbgState = state;

  assign countAfterPush = {1'b0, count} + (CW+1)'(1) - {{CW{1'b0}}, pop};
  assign pushEntry      = '{instruction: imemData, pc: fetchPc};

  always_comb begin
    stateNext = state;
    pcNext    = fetchPc;
    pushEn    = 1'b0;
    case (state)
      FETCH_REQ: if (transfer) stateNext = FETCH_WAIT;
      FETCH_WAIT:
        if (imemValid) begin
          pushEn    = 1'b1;
          pcNext    = fetchPc + 32'd4;
          stateNext = (countAfterPush < (CW+1)'(FIFO_DEPTH)) ? FETCH_REQ : FETCH_IDLE;
        end
      FETCH_DISCARD: if (imemValid) stateNext = FETCH_REQ;
      FETCH_IDLE:    if (pop) stateNext = FETCH_REQ;
      default:       stateNext = FETCH_REQ;
    endcase
    // A redirect overrides everything; only a request already handed to memory forces DISCARD.
    if (iRedirect) begin
      pushEn = 1'b0;
      pcNext = wordAlign(iRedirectPc);
      case (state)
        FETCH_REQ:     stateNext = transfer ? FETCH_DISCARD : FETCH_REQ;
        FETCH_WAIT:    stateNext = imemValid ? FETCH_REQ : FETCH_DISCARD;
        FETCH_DISCARD: stateNext = imemValid ? FETCH_REQ : FETCH_DISCARD;
        default:       stateNext = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH_REQ;
      fetchPc   <= RESET_PC;
      reqEnable <= 1'b0;
    end else begin
      state     <= stateNext;
      fetchPc   <= pcNext;
      reqEnable <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetchEntry_t))
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (pushEn),
    .pushData  (pushEntry),
    .pop       (pop),
    .flush     (iRedirect),
    .count     (count),
    .headValid (oValid),
    .headData  (headEntry)
  );

  assign oInstruction = headEntry.instruction;
  assign oPc          = headEntry.pc;

endmodule
